instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder for the processor's 32-bit ISA: the write side of the instruction format that the control decoder reads.
- Accepts mnemonic-level commands (operation select, register fields, ALU func, immediate) over a valid/ready stream.
- Produces encoded instruction words with sequential byte addresses for loading instruction memory from the test bench or boot loader.
- Sits between the program source and the instruction-memory write port.

Parameters:
ADDR_W, 10, width of Out_Addr (byte address); address space 2^ADDR_W bytes
BASE_ADDR, 0, byte address of the first emitted word (multiple of 4)

Ports:
Clk  input  1  clock, all logic on rising edge
Reset_n  input  1  synchronous active-low reset
Start  input  1  one-cycle pulse, begins a program load (honoured only in IDLE, DONE, ERR)
In_Valid  input  1  command valid
In_Ready  output  1  command accepted when In_Valid & In_Ready
In_Op  input  4  0 ALU, 1 lw, 2 lb, 3 sw, 4 sb, 5 b, 6 beq, 7 bne, 8 li, 9 addi, 10 andi, 11 ori, 12-15 illegal
In_Last  input  1  marks the final command of the program
In_Rs  input  5  source register
In_Rd  input  5  destination / second compare register
In_Rt  input  5  ALU second operand register
In_Func  input  4  ALU function (ALU op only)
In_Imm  input  16  immediate / branch offset
Out_Valid  output  1  encoded word valid
Out_Ready  input  1  memory accepts word
Out_Instr  output  32  encoded instruction
Out_Addr  output  ADDR_W  byte address of Out_Instr
Busy  output  1  high in RUN, DRAIN
Done  output  1  high in DONE
Err  output  1  sticky error, cleared by Start or reset
Word_Count  output  ADDR_W-1  words emitted since Start

Behaviour:
- Encoding:
  - Opcode in [31:26]: ALU 100000, lw 001111, lb 000011, sw 011111, sb 000111, b 111111, beq 000000, bne 000001, li 111000, addi 110000, andi 110010, ori 110011.
  - ALU: rs [25:21], rd [20:16], rt [15:11], [10:4] = 0, func [3:0].
  - All other ops: rs [25:21], rd [20:16], imm [15:0].
  - li and b force rs = 0; b also forces rd = 0.
- Reset (Reset_n = 0 at edge):
  - State IDLE.
  - Out_Valid, In_Ready, Busy, Done, Err = 0.
  - Out_Instr = 0, Out_Addr = BASE_ADDR, Word_Count = 0.
  - Reset mid-load discards any pending word; no further output.
- FSM states: IDLE, RUN, DRAIN, DONE, ERR.
  - IDLE/DONE/ERR + Start: go to RUN; address = BASE_ADDR, Word_Count = 0, Err = 0, Done = 0.
  - RUN:
    - In_Ready = ~Out_Valid | Out_Ready (single output register, full throughput, no bubbles).
    - Accepting a legal command loads Out_Instr/Out_Addr on the next edge, sets Out_Valid, and increments address by 4.
  - Output handshake:
    - Word leaves when Out_Valid & Out_Ready; Word_Count increments that edge.
    - Out_Instr and Out_Addr hold stable while Out_Valid & ~Out_Ready.
  - Accepted In_Last (legal op): go to DRAIN, In_Ready = 0.
  - DRAIN: when the output register empties, go to DONE (or HALT step, see Optional Feature).
  - Illegal In_Op accepted:
    - Nothing emitted; Err = 1.
    - If a word is pending, go to DRAIN and then ERR instead of DONE; otherwise go directly to ERR.
  - Address wrap: accepting a command at the last word address (2^ADDR_W - 4):
    - Word emitted normally; Err = 1; address wraps to 0.
    - FSM goes to DRAIN then ERR regardless of In_Last.
  - Start in RUN/DRAIN is ignored.
  - Simultaneous input accept and output accept: both occur; the register reloads.
  - ERR: In_Ready = 0 until Start.

Optional Feature:
- Macro INSTR_ENC_HALT_EN.
- Defined: after the last word drains, the block emits halt word 0xFC00FFFF (b with offset -1, branch-to-self) at the next address, then enters DONE. The halt word counts in Word_Count. It is not appended on the ERR path.
- Undefined: DRAIN goes straight to DONE.

Test Plan:
- Start; addi rs=1 rd=2 imm=5 with Last, Out_Ready=1 -> Out_Instr=0xC0220005, Out_Addr=0, Word_Count=1, Done=1 (with HALT_EN: second word 0xFC00FFFF at addr 4, Word_Count=2).
- ALU rs=3 rd=4 rt=5 func=2 then lw rs=0 rd=7 imm=8, back-to-back -> 0x80642802 @0 and 0x3C070008 @4 on consecutive cycles, no bubble.
- Hold Out_Ready=0 for 3 cycles with a word pending -> In_Ready=0, Out_Instr/Out_Addr unchanged; release -> the next word follows the cycle after.
- In_Op=13 mid-program -> Err=1, no Out_Valid for that command, ERR after drain, In_Ready=0; Start clears Err.
- ADDR_W=4, five commands -> fourth word at 0xC sets Err and wraps; FSM ends in ERR; fifth command not accepted.
- Reset_n=0 with Out_Valid=1 -> next edge Out_Valid=0, Out_Addr=BASE_ADDR, state IDLE.

Source files
------------

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - command and encoded-word streams of instr_encoder
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              In_Valid;
  logic              In_Ready;
  logic [3:0]        In_Op;
  logic              In_Last;
  logic [4:0]        In_Rs;
  logic [4:0]        In_Rd;
  logic [4:0]        In_Rt;
  logic [3:0]        In_Func;
  logic [15:0]       In_Imm;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [31:0]       Out_Instr;
  logic [ADDR_W-1:0] Out_Addr;

  modport master (
    output In_Valid, In_Op, In_Last, In_Rs, In_Rd, In_Rt, In_Func, In_Imm, Out_Ready,
    input  In_Ready, Out_Valid, Out_Instr, Out_Addr
  );

  modport slave (
    input  In_Valid, In_Op, In_Last, In_Rs, In_Rd, In_Rt, In_Func, In_Imm, Out_Ready,
    output In_Ready, Out_Valid, Out_Instr, Out_Addr
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes mnemonic commands into 32-bit instruction words with sequential byte addresses
// Optional halt word after the last instruction: define INSTR_ENC_HALT_EN.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  instr_encoder_if.slave    bus,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-2:0] Word_Count
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} encState;

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WORD  = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-2:0] COUNT_STEP = (ADDR_W-1)'(1);
  localparam logic [31:0]       HALT_WORD  = 32'hFC00_FFFF;
  localparam logic [3:0]        OP_ALU     = 4'd0;
  localparam logic [3:0]        OP_B       = 4'd5;
  localparam logic [3:0]        OP_LI      = 4'd8;

  encState           state;
  logic [ADDR_W-1:0] nextAddr;
  logic [31:0]       cmdWord;
  logic              cmdLegal;
  logic              inFire;
  logic              outFire;
`ifdef INSTR_ENC_HALT_EN
  logic              haltSent;
`endif

  function automatic logic [5:0] opcodeOf(input logic [3:0] op);
    case (op)
      4'd0:    opcodeOf = 6'b100000;
      4'd1:    opcodeOf = 6'b001111;
      4'd2:    opcodeOf = 6'b000011;
      4'd3:    opcodeOf = 6'b011111;
      4'd4:    opcodeOf = 6'b000111;
      4'd5:    opcodeOf = 6'b111111;
      4'd6:    opcodeOf = 6'b000000;
      4'd7:    opcodeOf = 6'b000001;
      4'd8:    opcodeOf = 6'b111000;
      4'd9:    opcodeOf = 6'b110000;
      4'd10:   opcodeOf = 6'b110010;
      4'd11:   opcodeOf = 6'b110011;
      default: opcodeOf = 6'b000000;
    endcase
  endfunction

  always_comb begin
    cmdWord = {opcodeOf(bus.In_Op), bus.In_Rs, bus.In_Rd, bus.In_Imm};
    if (bus.In_Op == OP_ALU) begin
      cmdWord = {opcodeOf(bus.In_Op), bus.In_Rs, bus.In_Rd, bus.In_Rt, 7'd0, bus.In_Func};
    end else if (bus.In_Op == OP_LI) begin
      cmdWord[25:21] = 5'd0;
    end else if (bus.In_Op == OP_B) begin
      cmdWord[25:16] = 10'd0;
    end
  end

  assign cmdLegal     = !(bus.In_Op[3] && bus.In_Op[2]);
  // Single output register: a new command may enter whenever the register is empty or draining this cycle.
  assign bus.In_Ready = (state == RUN) && (!bus.Out_Valid || bus.Out_Ready);
  assign inFire       = bus.In_Valid && bus.In_Ready;
  assign outFire      = bus.Out_Valid && bus.Out_Ready;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= IDLE;
      nextAddr      <= BASE;
      bus.Out_Valid <= 1'b0;
      bus.Out_Instr <= 32'd0;
      bus.Out_Addr  <= BASE;
      Word_Count    <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Err           <= 1'b0;
`ifdef INSTR_ENC_HALT_EN
      haltSent      <= 1'b0;
`endif
    end else begin
      if (outFire) begin
        bus.Out_Valid <= 1'b0;
        Word_Count    <= Word_Count + COUNT_STEP;
      end
      unique case (state)
        IDLE, DONE, ERR: begin
          if (Start) begin
            state      <= RUN;
            nextAddr   <= BASE;
            Word_Count <= '0;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            Err        <= 1'b0;
`ifdef INSTR_ENC_HALT_EN
            haltSent   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (inFire) begin
            if (!cmdLegal) begin
              Err <= 1'b1;
              if (bus.Out_Valid) begin
                state <= DRAIN;
              end else begin
                state <= ERR;
                Busy  <= 1'b0;
              end
            end else begin
              bus.Out_Instr <= cmdWord;
              bus.Out_Addr  <= nextAddr;
              bus.Out_Valid <= 1'b1;
              nextAddr      <= nextAddr + ADDR_STEP;
              // The last word slot still emits, but the wrap ends the program in ERR.
              if (nextAddr == LAST_WORD) begin
                Err   <= 1'b1;
                state <= DRAIN;
              end else if (bus.In_Last) begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (!bus.Out_Valid || bus.Out_Ready) begin
            if (Err) begin
              state <= ERR;
              Busy  <= 1'b0;
            end
`ifdef INSTR_ENC_HALT_EN
            else if (!haltSent) begin
              bus.Out_Instr <= HALT_WORD;
              bus.Out_Addr  <= nextAddr;
              bus.Out_Valid <= 1'b1;
              nextAddr      <= nextAddr + ADDR_STEP;
              haltSent      <= 1'b1;
            end
`endif
            else begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed testbench for instr_encoder (10-bit and 4-bit address instances)
module tb_instr_encoder;

`ifdef INSTR_ENC_HALT_EN
  localparam int HALT_WORDS = 1;
`else
  localparam int HALT_WORDS = 0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n = 1'b0;
  logic        start10 = 1'b0;
  logic        start4  = 1'b0;
  logic        inValid = 1'b0;
  logic [3:0]  inOp    = '0;
  logic        inLast  = 1'b0;
  logic [4:0]  inRs    = '0;
  logic [4:0]  inRd    = '0;
  logic [4:0]  inRt    = '0;
  logic [3:0]  inFunc  = '0;
  logic [15:0] inImm   = '0;
  logic        outReady = 1'b0;

  logic       busy10, done10, err10;
  logic [8:0] wc10;
  logic       busy4, done4, err4;
  logic [2:0] wc4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] q10I[$];
  logic [9:0]  q10A[$];
  int          q10C[$];
  logic [31:0] q4I[$];
  logic [3:0]  q4A[$];

  instr_encoder_if #(.ADDR_W(10)) b10 ();
  instr_encoder_if #(.ADDR_W(4))  b4 ();

  assign b10.In_Valid = inValid;  assign b4.In_Valid = inValid;
  assign b10.In_Op    = inOp;     assign b4.In_Op    = inOp;
  assign b10.In_Last  = inLast;   assign b4.In_Last  = inLast;
  assign b10.In_Rs    = inRs;     assign b4.In_Rs    = inRs;
  assign b10.In_Rd    = inRd;     assign b4.In_Rd    = inRd;
  assign b10.In_Rt    = inRt;     assign b4.In_Rt    = inRt;
  assign b10.In_Func  = inFunc;   assign b4.In_Func  = inFunc;
  assign b10.In_Imm   = inImm;    assign b4.In_Imm   = inImm;
  assign b10.Out_Ready = outReady; assign b4.Out_Ready = outReady;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u10 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start10), .bus(b10),
    .Busy(busy10), .Done(done10), .Err(err10), .Word_Count(wc10)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) u4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start4), .bus(b4),
    .Busy(busy4), .Done(done4), .Err(err4), .Word_Count(wc4)
  );

  always @(posedge Clk) cyc <= cyc + 1;

  // Inputs change only at posedge+1, so a word seen valid&ready here transfers on the next edge.
  always @(negedge Clk) begin
    if (b10.Out_Valid && b10.Out_Ready) begin
      q10I.push_back(b10.Out_Instr); q10A.push_back(b10.Out_Addr); q10C.push_back(cyc);
    end
    if (b4.Out_Valid && b4.Out_Ready) begin
      q4I.push_back(b4.Out_Instr); q4A.push_back(b4.Out_Addr);
    end
  end

  task automatic stepIn();
    @(posedge Clk); #1;
  endtask

  task automatic clearQ();
    q10I.delete(); q10A.delete(); q10C.delete(); q4I.delete(); q4A.delete();
  endtask

  task automatic setCmd(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rd,
                        input logic [4:0] rt, input logic [3:0] func, input logic [15:0] imm,
                        input logic last);
    inValid = 1'b1; inOp = op; inRs = rs; inRd = rd; inRt = rt; inFunc = func; inImm = imm; inLast = last;
  endtask

  task automatic sendCmd(input int sel, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rd,
                         input logic [4:0] rt, input logic [3:0] func, input logic [15:0] imm,
                         input logic last);
    bit got = 1'b0;
    setCmd(op, rs, rd, rt, func, imm, last);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge Clk);
      if (sel == 4 ? b4.In_Ready : b10.In_Ready) got = 1'b1;
      @(posedge Clk); #1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL accept_timeout op=%0d got=not_accepted exp=accepted", op); end
  endtask

  task automatic idleIn();
    inValid = 1'b0; inLast = 1'b0;
  endtask

  task automatic pulseStart(input int sel);
    if (sel == 4) start4 = 1'b1; else start10 = 1'b1;
    stepIn();
    start4 = 1'b0; start10 = 1'b0;
  endtask

  task automatic waitNotBusy(input int sel);
    bit idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge Clk);
      if (!(sel == 4 ? busy4 : busy10)) idle = 1'b1;
    end
    stepIn();
    checks++;
    if (!idle) begin errors++; $display("FAIL busy_timeout got=busy exp=idle"); end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; idleIn(); outReady = 1'b0;
    repeat (2) stepIn();
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (b10.Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", b10.Out_Valid); end
    checks++; if (b10.In_Ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", b10.In_Ready); end
    checks++; if ({busy10, done10, err10} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {busy10, done10, err10}); end
    checks++; if (b10.Out_Instr !== 32'd0) begin errors++; $display("FAIL rst_instr got=%h exp=0", b10.Out_Instr); end
    checks++; if (b10.Out_Addr !== 10'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0", b10.Out_Addr); end
    checks++; if (wc10 !== 9'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", wc10); end
    stepIn();
  endtask

  task automatic test_single();
    clearQ(); outReady = 1'b1;
    pulseStart(10);
    sendCmd(10, 4'd9, 5'd1, 5'd2, 5'd0, 4'd0, 16'd5, 1'b1);
    idleIn();
    waitNotBusy(10);
    checks++; if (q10I.size() != 1 + HALT_WORDS) begin errors++; $display("FAIL single_nwords got=%0d exp=%0d", q10I.size(), 1 + HALT_WORDS); end
    if (q10I.size() >= 1) begin
      checks++; if (q10I[0] !== 32'hC022_0005) begin errors++; $display("FAIL single_instr got=%h exp=c0220005", q10I[0]); end
      checks++; if (q10A[0] !== 10'd0) begin errors++; $display("FAIL single_addr got=%h exp=0", q10A[0]); end
    end
`ifdef INSTR_ENC_HALT_EN
    if (q10I.size() >= 2) begin
      checks++; if (q10I[1] !== 32'hFC00_FFFF) begin errors++; $display("FAIL halt_instr got=%h exp=fc00ffff", q10I[1]); end
      checks++; if (q10A[1] !== 10'd4) begin errors++; $display("FAIL halt_addr got=%h exp=4", q10A[1]); end
    end
`endif
    checks++; if (wc10 !== 9'(1 + HALT_WORDS)) begin errors++; $display("FAIL single_count got=%0d exp=%0d", wc10, 1 + HALT_WORDS); end
    checks++; if ({busy10, done10, err10} !== 3'b010) begin errors++; $display("FAIL single_flags got=%b exp=010", {busy10, done10, err10}); end
  endtask

  task automatic test_back_to_back();
    clearQ(); outReady = 1'b1;
    pulseStart(10);
    sendCmd(10, 4'd0, 5'd3, 5'd4, 5'd5, 4'd2, 16'hFFFF, 1'b0);
    sendCmd(10, 4'd1, 5'd0, 5'd7, 5'd0, 4'd0, 16'd8, 1'b1);
    idleIn();
    waitNotBusy(10);
    if (q10I.size() >= 2) begin
      checks++; if (q10I[0] !== 32'h8064_2802) begin errors++; $display("FAIL b2b_alu got=%h exp=80642802", q10I[0]); end
      checks++; if (q10I[1] !== 32'h3C07_0008) begin errors++; $display("FAIL b2b_lw got=%h exp=3c070008", q10I[1]); end
      checks++; if (q10A[1] !== 10'd4) begin errors++; $display("FAIL b2b_addr got=%h exp=4", q10A[1]); end
      checks++; if (q10C[1] != q10C[0] + 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=1", q10C[1] - q10C[0]); end
    end else begin
      checks++; errors++; $display("FAIL b2b_nwords got=%0d exp=%0d", q10I.size(), 2 + HALT_WORDS);
    end
    checks++; if (wc10 !== 9'(2 + HALT_WORDS)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", wc10, 2 + HALT_WORDS); end
  endtask

  task automatic test_backpressure();
    clearQ(); outReady = 1'b0;
    pulseStart(10);
    sendCmd(10, 4'd11, 5'd2, 5'd3, 5'd0, 4'd0, 16'h00F0, 1'b0);
    setCmd(4'd10, 5'd5, 5'd6, 5'd0, 4'd0, 16'h1234, 1'b1);
    repeat (3) begin
      @(negedge Clk);
      checks++; if (b10.In_Ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", b10.In_Ready); end
      checks++; if (b10.Out_Valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", b10.Out_Valid); end
      checks++; if (b10.Out_Instr !== 32'hCC43_00F0) begin errors++; $display("FAIL bp_hold_instr got=%h exp=cc4300f0", b10.Out_Instr); end
      checks++; if (b10.Out_Addr !== 10'd0) begin errors++; $display("FAIL bp_hold_addr got=%h exp=0", b10.Out_Addr); end
      stepIn();
    end
    outReady = 1'b1;
    sendCmd(10, 4'd10, 5'd5, 5'd6, 5'd0, 4'd0, 16'h1234, 1'b1);
    idleIn();
    waitNotBusy(10);
    if (q10I.size() >= 2) begin
      checks++; if (q10I[1] !== 32'hC8A6_1234) begin errors++; $display("FAIL bp_second got=%h exp=c8a61234", q10I[1]); end
      checks++; if (q10A[1] !== 10'd4) begin errors++; $display("FAIL bp_second_addr got=%h exp=4", q10A[1]); end
      checks++; if (q10C[1] != q10C[0] + 1) begin errors++; $display("FAIL bp_follow got=%0d exp=1", q10C[1] - q10C[0]); end
    end else begin
      checks++; errors++; $display("FAIL bp_nwords got=%0d exp=%0d", q10I.size(), 2 + HALT_WORDS);
    end
  endtask

  task automatic test_illegal();
    clearQ(); outReady = 1'b1;
    pulseStart(10);
    sendCmd(10, 4'd4, 5'd1, 5'd2, 5'd0, 4'd0, 16'd4, 1'b0);
    sendCmd(10, 4'd13, 5'd1, 5'd1, 5'd1, 4'd1, 16'd1, 1'b0);
    setCmd(4'd9, 5'd1, 5'd1, 5'd0, 4'd0, 16'd1, 1'b0);
    repeat (5) stepIn();
    @(negedge Clk);
    checks++; if (q10I.size() != 1) begin errors++; $display("FAIL ill_nwords got=%0d exp=1", q10I.size()); end
    if (q10I.size() >= 1) begin
      checks++; if (q10I[0] !== 32'h1C22_0004) begin errors++; $display("FAIL ill_sb got=%h exp=1c220004", q10I[0]); end
    end
    checks++; if ({busy10, done10, err10} !== 3'b001) begin errors++; $display("FAIL ill_flags got=%b exp=001", {busy10, done10, err10}); end
    checks++; if (b10.In_Ready !== 1'b0) begin errors++; $display("FAIL ill_in_ready got=%b exp=0", b10.In_Ready); end
    stepIn();
    idleIn();
    pulseStart(10);
    @(negedge Clk);
    checks++; if ({busy10, err10} !== 2'b10) begin errors++; $display("FAIL ill_restart got=%b exp=10", {busy10, err10}); end
    stepIn();
    sendCmd(10, 4'd7, 5'd1, 5'd2, 5'd0, 4'd0, 16'd3, 1'b1);
    idleIn();
    waitNotBusy(10);
    checks++; if ({done10, err10} !== 2'b10) begin errors++; $display("FAIL ill_recover got=%b exp=10", {done10, err10}); end
  endtask

  task automatic test_wrap();
    int seen = 0;
    clearQ(); outReady = 1'b1;
    pulseStart(4);
    sendCmd(4, 4'd8, 5'd7, 5'd1, 5'd0, 4'd0, 16'h0010, 1'b0);
    sendCmd(4, 4'd9, 5'd1, 5'd2, 5'd0, 4'd0, 16'd2, 1'b0);
    sendCmd(4, 4'd9, 5'd1, 5'd3, 5'd0, 4'd0, 16'd3, 1'b0);
    sendCmd(4, 4'd9, 5'd1, 5'd4, 5'd0, 4'd0, 16'd4, 1'b0);
    setCmd(4'd9, 5'd1, 5'd5, 5'd0, 4'd0, 16'd5, 1'b0);
    repeat (6) begin
      @(negedge Clk);
      if (b4.In_Ready) seen++;
      stepIn();
    end
    idleIn();
    checks++; if (seen != 0) begin errors++; $display("FAIL wrap_fifth_ready got=%0d exp=0", seen); end
    checks++; if (q4I.size() != 4) begin errors++; $display("FAIL wrap_nwords got=%0d exp=4", q4I.size()); end
    if (q4I.size() >= 4) begin
      checks++; if (q4I[0] !== 32'hE001_0010) begin errors++; $display("FAIL wrap_li got=%h exp=e0010010", q4I[0]); end
      checks++; if (q4A[3] !== 4'hC) begin errors++; $display("FAIL wrap_last_addr got=%h exp=c", q4A[3]); end
    end
    checks++; if ({busy4, done4, err4} !== 3'b001) begin errors++; $display("FAIL wrap_flags got=%b exp=001", {busy4, done4, err4}); end
    checks++; if (wc4 !== 3'd4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", wc4); end
  endtask

  task automatic test_reset_midload();
    clearQ(); outReady = 1'b0;
    pulseStart(10);
    sendCmd(10, 4'd9, 5'd1, 5'd2, 5'd0, 4'd0, 16'd9, 1'b0);
    @(negedge Clk);
    checks++; if (b10.Out_Valid !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", b10.Out_Valid); end
    stepIn();
    Reset_n = 1'b0;
    stepIn();
    @(negedge Clk);
    checks++; if (b10.Out_Valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", b10.Out_Valid); end
    checks++; if (b10.Out_Addr !== 10'd0) begin errors++; $display("FAIL mid_addr got=%h exp=0", b10.Out_Addr); end
    checks++; if ({busy10, b10.In_Ready} !== 2'b00) begin errors++; $display("FAIL mid_idle got=%b exp=00", {busy10, b10.In_Ready}); end
    stepIn();
    Reset_n = 1'b1; outReady = 1'b1;
    repeat (4) stepIn();
    idleIn();
    checks++; if (q10I.size() != 0) begin errors++; $display("FAIL mid_no_output got=%0d exp=0", q10I.size()); end
  endtask

  initial begin
    stepIn();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
